// File: rtl/functional_memory_pkg.sv
// Shared types for the multi-port functional memory: per-port FSM states and
// the latency counter width helper.
package functional_memory_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_WAIT  = 2'd1,
    WRITE_WAIT = 2'd2
  } port_state_e;

  function automatic int latency_cnt_width(input int read_lat, input int write_lat);
    int max_lat;
    max_lat = (read_lat > write_lat) ? read_lat : write_lat;
    return (max_lat < 1) ? 1 : $clog2(max_lat + 1);
  endfunction

endpackage

// File: rtl/functional_memory_port_ctrl.sv
// One request port: FSM, latency counter and latched request. The fire
// outputs are high in the last wait cycle so the owner acts on that edge.
module functional_memory_port_ctrl
  import functional_memory_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 3,
  parameter int PAYLOAD_WIDTH = 16,
  parameter int READ_LATENCY  = 9,
  parameter int WRITE_LATENCY = 14
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     address_valid_i,
  input  logic [ADDRESS_WIDTH-1:0] address_i,
  input  logic [PAYLOAD_WIDTH-1:0] payload_i,
  input  logic                     write_data_valid_i,
  input  logic                     read_write_select_i,
  output logic                     port_ready_o,
  output logic                     read_fire_o,
  output logic                     write_fire_o,
  output logic [ADDRESS_WIDTH-1:0] op_address_o,
  output logic [PAYLOAD_WIDTH-1:0] op_payload_o,
  output logic                     read_data_valid_o,
  output logic                     write_done_o
);

  localparam int CW = latency_cnt_width(READ_LATENCY, WRITE_LATENCY);
  localparam logic [CW-1:0] RD_LOAD = CW'(READ_LATENCY - 1);
  localparam logic [CW-1:0] WR_LOAD = CW'(WRITE_LATENCY - 1);

  port_state_e              state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [PAYLOAD_WIDTH-1:0] payload_q, payload_d;
  logic                     rd_pulse_q, rd_pulse_d;
  logic                     wr_pulse_q, wr_pulse_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    payload_d  = payload_q;
    rd_pulse_d = 1'b0;
    wr_pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (address_valid_i && !read_write_select_i) begin
          state_d = READ_WAIT;
          cnt_d   = RD_LOAD;
          addr_d  = address_i;
        end else if (address_valid_i && write_data_valid_i) begin
          state_d   = WRITE_WAIT;
          cnt_d     = WR_LOAD;
          addr_d    = address_i;
          payload_d = payload_i;
        end
      end
      READ_WAIT: begin
        if (cnt_q == '0) begin
          state_d    = IDLE;
          rd_pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WRITE_WAIT: begin
        if (cnt_q == '0) begin
          state_d    = IDLE;
          wr_pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      payload_q  <= '0;
      rd_pulse_q <= 1'b0;
      wr_pulse_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      payload_q  <= payload_d;
      rd_pulse_q <= rd_pulse_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

  // Gated by reset so an operation aborted on its completion edge leaves no trace.
  assign read_fire_o       = reset_n_i && (state_q == READ_WAIT) && (cnt_q == '0);
  assign write_fire_o      = reset_n_i && (state_q == WRITE_WAIT) && (cnt_q == '0);
  assign port_ready_o      = (state_q == IDLE);
  assign op_address_o      = addr_q;
  assign op_payload_o      = payload_q;
  assign read_data_valid_o = rd_pulse_q;
  assign write_done_o      = wr_pulse_q;

endmodule

// File: rtl/multi_port_functional_memory.sv
// Latency-accurate shared memory with NUM_PORTS independent request ports.
// Optional per-byte write strobes: MULTI_PORT_FUNCTIONAL_MEMORY_BYTE_ENABLE_EN.
module multi_port_functional_memory
  import functional_memory_pkg::*;
#(
  parameter int NUM_PORTS     = 2,
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 3,
  parameter int MEMORY_DEPTH  = 8,
  parameter int READ_LATENCY  = 9,
  parameter int WRITE_LATENCY = 14
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic [NUM_PORTS*ADDRESS_WIDTH-1:0] address_i,
  input  logic [NUM_PORTS-1:0]               address_valid_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]    write_data_i,
  input  logic [NUM_PORTS-1:0]               write_data_valid_i,
`ifdef MULTI_PORT_FUNCTIONAL_MEMORY_BYTE_ENABLE_EN
  input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0] write_strobe_i,
`endif
  input  logic [NUM_PORTS-1:0]               read_write_select_i,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]    read_data_o,
  output logic [NUM_PORTS-1:0]               read_data_valid_o,
  output logic [NUM_PORTS-1:0]               write_done_o,
  output logic [NUM_PORTS-1:0]               port_ready_o
);

  localparam int SW = DATA_WIDTH / 8;
`ifdef MULTI_PORT_FUNCTIONAL_MEMORY_BYTE_ENABLE_EN
  localparam int PW = DATA_WIDTH + SW;
`else
  localparam int PW = DATA_WIDTH;
`endif
  localparam int IW = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;

  logic [DATA_WIDTH-1:0]           mem_q [MEMORY_DEPTH];
  logic [NUM_PORTS*DATA_WIDTH-1:0] read_data_q, read_data_d;
  logic [NUM_PORTS-1:0]            read_fire, write_fire, in_range;
  logic [ADDRESS_WIDTH-1:0]        op_addr [NUM_PORTS];
  logic [IW-1:0]                   mem_idx [NUM_PORTS];
  logic [PW-1:0]                   op_payload [NUM_PORTS];

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      logic [PW-1:0] payload_in;
`ifdef MULTI_PORT_FUNCTIONAL_MEMORY_BYTE_ENABLE_EN
      assign payload_in = {write_strobe_i[gi*SW +: SW], write_data_i[gi*DATA_WIDTH +: DATA_WIDTH]};
`else
      assign payload_in = write_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
`endif
      assign in_range[gi] = (32'(op_addr[gi]) < 32'(MEMORY_DEPTH));
      assign mem_idx[gi]  = op_addr[gi][IW-1:0];

      functional_memory_port_ctrl #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .PAYLOAD_WIDTH(PW),
        .READ_LATENCY (READ_LATENCY),
        .WRITE_LATENCY(WRITE_LATENCY)
      ) u_ctrl (
        .clk_i              (clk_i),
        .reset_n_i          (reset_n_i),
        .address_valid_i    (address_valid_i[gi]),
        .address_i          (address_i[gi*ADDRESS_WIDTH +: ADDRESS_WIDTH]),
        .payload_i          (payload_in),
        .write_data_valid_i (write_data_valid_i[gi]),
        .read_write_select_i(read_write_select_i[gi]),
        .port_ready_o       (port_ready_o[gi]),
        .read_fire_o        (read_fire[gi]),
        .write_fire_o       (write_fire[gi]),
        .op_address_o       (op_addr[gi]),
        .op_payload_o       (op_payload[gi]),
        .read_data_valid_o  (read_data_valid_o[gi]),
        .write_done_o       (write_done_o[gi])
      );
    end
  endgenerate

  // Reads sample the array before this edge's writes land.
  always_comb begin
    read_data_d = read_data_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (read_fire[p]) begin
        read_data_d[p*DATA_WIDTH +: DATA_WIDTH] = in_range[p] ? mem_q[mem_idx[p]] : '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      read_data_q <= '0;
    end else begin
      read_data_q <= read_data_d;
    end
  end

  // Ascending loop: on a same-address collision the highest port's write lands last.
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (write_fire[p] && in_range[p]) begin
`ifdef MULTI_PORT_FUNCTIONAL_MEMORY_BYTE_ENABLE_EN
        for (int b = 0; b < SW; b++) begin
          if (op_payload[p][DATA_WIDTH + b]) begin
            mem_q[mem_idx[p]][b*8 +: 8] <= op_payload[p][b*8 +: 8];
          end
        end
`else
        mem_q[mem_idx[p]] <= op_payload[p][DATA_WIDTH-1:0];
`endif
      end
    end
  end

  assign read_data_o = read_data_q;

endmodule

// File: tb/tb_multi_port_functional_memory.sv
// Directed bench: a driver queues the expected completion (kind, data, cycle)
// and a negedge monitor pops and checks whenever a port pulses.
module tb_multi_port_functional_memory;

  localparam int NP    = 2;
  localparam int DW    = 16;
  localparam int AW    = 3;
  localparam int DEPTH = 6;
  localparam int RL    = 9;
  localparam int WL    = 14;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic [NP*AW-1:0]   address_i = '0;
  logic [NP-1:0]      address_valid_i = '0;
  logic [NP*DW-1:0]   write_data_i = '0;
  logic [NP-1:0]      write_data_valid_i = '0;
  logic [NP-1:0]      read_write_select_i = '0;
  logic [NP*DW-1:0]   read_data_o;
  logic [NP-1:0]      read_data_valid_o;
  logic [NP-1:0]      write_done_o;
  logic [NP-1:0]      port_ready_o;

  multi_port_functional_memory #(
    .NUM_PORTS    (NP),
    .DATA_WIDTH   (DW),
    .ADDRESS_WIDTH(AW),
    .MEMORY_DEPTH (DEPTH),
    .READ_LATENCY (RL),
    .WRITE_LATENCY(WL)
  ) dut (
    .clk_i              (clk),
    .reset_n_i          (reset_n),
    .address_i          (address_i),
    .address_valid_i    (address_valid_i),
    .write_data_i       (write_data_i),
    .write_data_valid_i (write_data_valid_i),
    .read_write_select_i(read_write_select_i),
    .read_data_o        (read_data_o),
    .read_data_valid_o  (read_data_valid_o),
    .write_done_o       (write_done_o),
    .port_ready_o       (port_ready_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit            is_wr;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t exp_q [NP][$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (read_data_valid_o[p] === 1'b1 || write_done_o[p] === 1'b1) begin
        if (exp_q[p].size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL p%0d_unexpected_pulse actual rdv=%b wd=%b required none at cycle %0d",
                   p, read_data_valid_o[p], write_done_o[p], cyc);
        end else begin
          exp_t e;
          e = exp_q[p].pop_front();
          check($sformatf("p%0d_kind", p), {31'b0, write_done_o[p]}, {31'b0, e.is_wr});
          check($sformatf("p%0d_cycle", p), cyc, e.due);
          if (!e.is_wr)
            check($sformatf("p%0d_rdata", p), {16'b0, read_data_o[p*DW +: DW]}, {16'b0, e.data});
          $display("port %0d %s done cycle=%0d data=%04h", p, e.is_wr ? "write" : "read ",
                   cyc, e.is_wr ? e.data : read_data_o[p*DW +: DW]);
        end
      end
    end
  end

  task automatic drive(input int p, input bit wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input bit dv);
    address_i[p*AW +: AW]    = a;
    address_valid_i[p]       = 1'b1;
    read_write_select_i[p]   = wr;
    write_data_i[p*DW +: DW] = d;
    write_data_valid_i[p]    = dv;
  endtask

  task automatic expect_op(input int p, input bit wr, input logic [DW-1:0] d);
    exp_t e;
    e.is_wr = wr;
    e.data  = d;
    e.due   = cyc + 1 + (wr ? WL : RL);
    exp_q[p].push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    address_valid_i    = '0;
    write_data_valid_i = '0;
  endtask

  task automatic wait_ready(input int p);
    int n = 0;
    while (port_ready_o[p] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (port_ready_o[p] !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL p%0d_ready_timeout actual=%b required=1", p, port_ready_o[p]);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q[0].size() != 0 || exp_q[1].size() != 0 || port_ready_o !== 2'b11) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_timeout actual pending=%0d/%0d ready=%b required 0/0 11",
               exp_q[0].size(), exp_q[1].size(), port_ready_o);
    end
    @(negedge clk);
  endtask

  task automatic do_write(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wait_ready(p);
    drive(p, 1'b1, a, d, 1'b1);
    expect_op(p, 1'b1, d);
    step();
  endtask

  task automatic do_read(input int p, input logic [AW-1:0] a, input logic [DW-1:0] exp_d);
    wait_ready(p);
    drive(p, 1'b0, a, '0, 1'b0);
    expect_op(p, 1'b0, exp_d);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("reset_ready", {30'b0, port_ready_o}, 32'h3);
    check("reset_rdv", {30'b0, read_data_valid_o}, 32'h0);
    check("reset_wd", {30'b0, write_done_o}, 32'h0);
    check("reset_rdata", read_data_o, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic write then read on port 0.
    do_write(0, 3'd3, 16'hBEEF);
    wait_idle();
    do_read(0, 3'd3, 16'hBEEF);
    wait_idle();
    repeat (3) @(negedge clk);
    check("rdata_hold", {16'b0, read_data_o[15:0]}, 32'hBEEF);

    // Same-cycle writes to one address: port 1 wins.
    wait_ready(0);
    wait_ready(1);
    drive(0, 1'b1, 3'd5, 16'h1111, 1'b1);
    drive(1, 1'b1, 3'd5, 16'h2222, 1'b1);
    expect_op(0, 1'b1, 16'h1111);
    expect_op(1, 1'b1, 16'h2222);
    step();
    wait_idle();
    do_read(1, 3'd5, 16'h2222);
    do_read(0, 3'd5, 16'h2222);
    wait_idle();

    // Port 1 read and port 0 write to addr 2 complete together: read sees old value.
    do_write(0, 3'd2, 16'h5A5A);
    wait_idle();
    drive(0, 1'b1, 3'd2, 16'h7777, 1'b1);
    expect_op(0, 1'b1, 16'h7777);
    step();
    repeat (4) @(negedge clk);
    drive(1, 1'b0, 3'd2, '0, 1'b0);
    expect_op(1, 1'b0, 16'h5A5A);
    step();
    wait_idle();
    do_read(1, 3'd2, 16'h7777);
    wait_idle();

    // Write without data valid is ignored.
    drive(0, 1'b1, 3'd4, 16'hDEAD, 1'b0);
    step();
    check("wdv_low_ready", {31'b0, port_ready_o[0]}, 32'h1);

    // Request while busy is ignored.
    do_read(0, 3'd3, 16'hBEEF);
    drive(0, 1'b1, 3'd3, 16'h0000, 1'b1);
    step();
    wait_idle();
    do_read(0, 3'd3, 16'hBEEF);
    wait_idle();

    // Out-of-range address: write dropped, read returns 0.
    do_write(1, 3'd7, 16'h9999);
    wait_idle();
    do_read(1, 3'd7, 16'h0000);
    do_read(0, 3'd3, 16'hBEEF);
    wait_idle();

    // Reset mid-flight aborts a read and a write with no pulses and no array update.
    drive(0, 1'b0, 3'd3, '0, 1'b0);
    drive(1, 1'b1, 3'd3, 16'h4444, 1'b1);
    step();
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("midreset_ready", {30'b0, port_ready_o}, 32'h3);
    check("midreset_rdata", read_data_o, 32'h0);
    check("midreset_rdv", {30'b0, read_data_valid_o}, 32'h0);
    repeat (16) @(negedge clk);
    do_read(1, 3'd3, 16'hBEEF);
    wait_idle();

    check("p0_queue_empty", exp_q[0].size(), 32'h0);
    check("p1_queue_empty", exp_q[1].size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
